// File: rtl/rf_access_pkg.sv
// rtl/rf_access_pkg.sv - shared types and defaults for the register-file access controller
package rf_access_pkg;

  localparam int DEF_LOCK_BASE = 13;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESP    = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  // ERR_LOCKED is reserved: blocked requesters see CMD_READY low instead of a response
  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DENIED  = 2'b01,
    ERR_LOCKED  = 2'b10,
    ERR_INVALID = 2'b11
  } err_t;

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - loadable 8-bit down-counter; done pulses on the final counted cycle
module lockout_timer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // Loaded with N, done is high in the N-th cycle after the load edge
  assign done = (cnt_q == 8'd1) && !load;

endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - privileged register-file access controller; RF_AUDIT_EN adds denial audit outputs
module rf_access_ctrl
  import rf_access_pkg::*;
#(
  parameter int LOCK_BASE   = DEF_LOCK_BASE,
  parameter int MAX_DENY    = 3,
  parameter int LOCKOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [3:0]  CMD_ADR,
  input  logic [11:0] CMD_WD,
  input  logic [11:0] CMD_UID,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic [1:0]  RSP_ERR,
  output logic [3:0]  RF_ADR1,
  output logic [3:0]  RF_WA,
  output logic        RF_EN,
  output logic [11:0] RF_WD,
  output logic [11:0] U_ID,
`ifdef RF_AUDIT_EN
  output logic [7:0]  AUDIT_CNT,
  output logic [3:0]  AUDIT_ADR,
`endif
  input  logic [15:0] RF_RS1
);

  state_t      state_q, state_d;
  err_t        rsp_err_q;
  logic [15:0] rsp_data_q;
  logic [3:0]  deny_q;
  logic [3:0]  rf_adr_q;
  logic        rf_en_q;
  logic [11:0] rf_wd_q;
  logic [11:0] uid_q;

  logic accept, is_invalid, is_denied, lock_hit, tmr_load, tmr_done;

  assign accept     = CMD_VALID && (state_q == IDLE);
  assign is_invalid = CMD_WR && (CMD_ADR == 4'd0);
  assign is_denied  = !is_invalid && (CMD_ADR >= 4'(LOCK_BASE)) && !CMD_UID[11];
  assign lock_hit   = (deny_q == 4'(MAX_DENY));
  assign tmr_load   = (state_q == RESP) && RSP_READY && lock_hit;

  lockout_timer u_lockout_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (tmr_load),
    .load_val (8'(LOCKOUT_CYC)),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (is_invalid || is_denied) ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (RSP_READY) state_d = lock_hit ? LOCKOUT : IDLE;
      LOCKOUT: if (tmr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_DATA  = 16'h0000;
    RSP_ERR   = 2'b00;
    case (state_q)
      IDLE: CMD_READY = 1'b1;
      RESP: begin
        RSP_VALID = 1'b1;
        RSP_DATA  = rsp_data_q;
        RSP_ERR   = rsp_err_q;
      end
      default: ;
    endcase
  end

  // RF drive registers default to zero each cycle, so they are only non-zero during ACCESS
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rf_adr_q   <= 4'd0;
      rf_en_q    <= 1'b0;
      rf_wd_q    <= 12'd0;
      uid_q      <= 12'd0;
      rsp_err_q  <= ERR_OK;
      rsp_data_q <= 16'h0000;
      deny_q     <= 4'd0;
    end else begin
      rf_adr_q <= 4'd0;
      rf_en_q  <= 1'b0;
      rf_wd_q  <= 12'd0;
      uid_q    <= 12'd0;
      case (state_q)
        IDLE: begin
          if (CMD_VALID) begin
            if (is_invalid) begin
              rsp_err_q  <= ERR_INVALID;
              rsp_data_q <= 16'h0000;
            end else if (is_denied) begin
              rsp_err_q  <= ERR_DENIED;
              rsp_data_q <= 16'h0000;
              deny_q     <= deny_q + 4'd1;
            end else begin
              rf_adr_q <= CMD_ADR;
              rf_en_q  <= CMD_WR;
              rf_wd_q  <= CMD_WR ? CMD_WD : 12'd0;
              uid_q    <= CMD_UID;
            end
          end
        end
        ACCESS: begin
          rsp_err_q  <= ERR_OK;
          rsp_data_q <= rf_en_q ? 16'h0000 : RF_RS1;
          deny_q     <= 4'd0;
        end
        RESP: begin
          if (RSP_READY && lock_hit) deny_q <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign RF_ADR1 = rf_adr_q;
  assign RF_WA   = rf_adr_q;
  assign RF_EN   = rf_en_q;
  assign RF_WD   = rf_wd_q;
  assign U_ID    = uid_q;

`ifdef RF_AUDIT_EN
  logic [7:0] audit_cnt_q;
  logic [3:0] audit_adr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      audit_cnt_q <= 8'd0;
      audit_adr_q <= 4'd0;
    end else if (accept && is_denied) begin
      if (audit_cnt_q != 8'hFF) audit_cnt_q <= audit_cnt_q + 8'd1;
      audit_adr_q <= CMD_ADR;
    end
  end

  assign AUDIT_CNT = audit_cnt_q;
  assign AUDIT_ADR = audit_adr_q;
`endif

endmodule
